// File: rtl/mux_sync_pkg.sv
// rtl/mux_sync_pkg.sv - shared types and limits for the mux_sync_rx receiver
package mux_sync_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rx_state_t;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/mux_sync_ch.sv
// rtl/mux_sync_ch.sv - one receive channel: req sync, edge detect, capture FSM, ack toggle; MUX_SYNC_RX_ERR_EN adds overrun flag
module mux_sync_ch
   import mux_sync_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_dst,
   input  logic              rst_dst_n,
   input  logic              req_toggle,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ack_toggle,
   input  logic              err_clr,
   output logic              err_overrun
);

   generate
      if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
         $error("mux_sync_ch: SYNC_STAGES must be within 2..4");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   req_edge;
   rx_state_t              state;

   // a level change on the last synchroniser stage is one new word
   assign req_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

   // resynchronise the request, then capture on an edge and hand back an ack once consumed
   always_ff @(posedge clk_dst) begin
      if (!rst_dst_n) begin
         sync_q     <= '0;
         hist_q     <= 1'b0;
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         ack_toggle <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_toggle};
         hist_q <= sync_q[SYNC_STAGES-1];
         case (state)
            IDLE: begin
               if (req_edge) begin
                  out_data  <= data_in;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               // an edge seen here is never recaptured; the held word stays put
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  ack_toggle <= ~ack_toggle;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUX_SYNC_RX_ERR_EN
   // sticky overrun: source toggled again before our ack; a new overrun beats a clear
   always_ff @(posedge clk_dst) begin
      if (!rst_dst_n) begin
         err_overrun <= 1'b0;
      end else if (req_edge && (state == HOLD)) begin
         err_overrun <= 1'b1;
      end else if (err_clr) begin
         err_overrun <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_overrun    = 1'b0;
`endif

endmodule

// File: rtl/mux_sync_rx.sv
// rtl/mux_sync_rx.sv - NUM_CH-channel toggle-handshake CDC receiver top; MUX_SYNC_RX_ERR_EN enables overrun detection
module mux_sync_rx
   import mux_sync_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk_dst,
   input  logic                     rst_dst_n,
   input  logic [NUM_CH-1:0]        req_toggle,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH-1:0]        ack_toggle,
   input  logic                     err_clr,
   output logic [NUM_CH-1:0]        err_overrun
);

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         mux_sync_ch #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_ch (
            .clk_dst     (clk_dst),
            .rst_dst_n   (rst_dst_n),
            .req_toggle  (req_toggle[c]),
            .data_in     (data_in[c*DATA_W +: DATA_W]),
            .out_data    (out_data[c*DATA_W +: DATA_W]),
            .out_valid   (out_valid[c]),
            .out_ready   (out_ready[c]),
            .ack_toggle  (ack_toggle[c]),
            .err_clr     (err_clr),
            .err_overrun (err_overrun[c])
         );
      end
   endgenerate

endmodule

// File: tb/tb_mux_sync_rx.sv
// tb/tb_mux_sync_rx.sv - directed self-checking bench for mux_sync_rx
module tb_mux_sync_rx;

`ifdef MUX_SYNC_RX_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, rdy, vld, ack, err;
   logic [31:0] din, dout;
   logic        err_clr;

   logic [1:0]  req3, vld3, ack3, err3, req4, vld4, ack4, err4;
   logic [31:0] din3, dout3, din4, dout4;

   int vec = 0;
   int miss = 0;

   always #5 clk = ~clk;

   mux_sync_rx #(.NUM_CH(2), .DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk_dst(clk), .rst_dst_n(rst_n), .req_toggle(req), .data_in(din),
      .out_data(dout), .out_valid(vld), .out_ready(rdy), .ack_toggle(ack),
      .err_clr(err_clr), .err_overrun(err)
   );

   mux_sync_rx #(.NUM_CH(2), .DATA_W(16), .SYNC_STAGES(3)) dut3 (
      .clk_dst(clk), .rst_dst_n(rst_n), .req_toggle(req3), .data_in(din3),
      .out_data(dout3), .out_valid(vld3), .out_ready(2'b11), .ack_toggle(ack3),
      .err_clr(1'b0), .err_overrun(err3)
   );

   mux_sync_rx #(.NUM_CH(2), .DATA_W(16), .SYNC_STAGES(4)) dut4 (
      .clk_dst(clk), .rst_dst_n(rst_n), .req_toggle(req4), .data_in(din4),
      .out_data(dout4), .out_valid(vld4), .out_ready(2'b11), .ack_toggle(ack4),
      .err_clr(1'b0), .err_overrun(err4)
   );

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vec++;
      assert (obs === expv) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; rdy = '0; din = '0; err_clr = 1'b0;
      req3 = '0; req4 = '0; din3 = '0; din4 = '0;
      cyc(3);
      chk("rst_valid", vld, 2'b00);
      chk("rst_ack", ack, 2'b00);
      chk("rst_err", err, 2'b00);
      chk("rst_data", dout, 32'h0);
      rst_n = 1'b1;

      // single transfer on ch0, ready high
      din[15:0] = 16'hA5C3; rdy = 2'b11; req[0] = 1'b1;
      cyc(1); chk("single_v_e0", vld, 2'b00);
      cyc(1); chk("single_v_e1", vld, 2'b00);
      cyc(1); chk("single_v_e2", vld, 2'b01);
      chk("single_data", dout[15:0], 16'hA5C3);
      chk("single_ack_e2", ack, 2'b00);
      cyc(1); chk("single_v_e3", vld, 2'b00);
      chk("single_ack_e3", ack, 2'b01);
      chk("single_ch1_data", dout[31:16], 16'h0000);

      // backpressure on ch0
      rdy[0] = 1'b0; din[15:0] = 16'h1234; req[0] = 1'b0;
      cyc(3); chk("bp_valid", vld, 2'b01);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("bp_hold_v", vld, 2'b01);
         chk("bp_hold_d", dout[15:0], 16'h1234);
         chk("bp_hold_ack", ack, 2'b01);
      end
      rdy[0] = 1'b1;
      cyc(1); chk("bp_rel_v", vld, 2'b00);
      chk("bp_rel_ack", ack, 2'b00);

      // overrun on ch1
      rdy[1] = 1'b0; din[31:16] = 16'h1111; req[1] = 1'b1;
      cyc(3); chk("ov_v", vld, 2'b10);
      chk("ov_d1", dout[31:16], 16'h1111);
      din[31:16] = 16'h2222; req[1] = 1'b0;
      cyc(3); chk("ov_hold_d", dout[31:16], 16'h1111);
      chk("ov_hold_v", vld, 2'b10);
      chk("ov_err", err, {ERR, 1'b0});
      chk("ov_ack_pre", ack, 2'b00);
      rdy[1] = 1'b1;
      cyc(1); chk("ov_acc_v", vld, 2'b00);
      chk("ov_acc_ack", ack, 2'b10);
      cyc(4); chk("ov_one_ack", ack, 2'b10);
      chk("ov_no_recap", vld, 2'b00);
      chk("ov_err_sticky", err, {ERR, 1'b0});
      err_clr = 1'b1;
      cyc(1); err_clr = 1'b0;
      chk("ov_err_clr", err, 2'b00);

      // concurrent channels, staggered ready
      rdy = 2'b00; din = {16'hFFFF, 16'h0001}; req = 2'b11;
      cyc(2); chk("cc_v_early", vld, 2'b00);
      cyc(1); chk("cc_v", vld, 2'b11);
      chk("cc_data", dout, {16'hFFFF, 16'h0001});
      rdy = 2'b01;
      cyc(1); chk("cc_v_stag", vld, 2'b10);
      chk("cc_ack_stag", ack, 2'b11);
      rdy = 2'b11;
      cyc(1); chk("cc_v_done", vld, 2'b00);
      chk("cc_ack_done", ack, 2'b01);
      chk("cc_data_kept", dout, {16'hFFFF, 16'h0001});

      // reset mid-HOLD, after an overrun
      rdy = 2'b00; din[15:0] = 16'hBEEF; req[0] = 1'b0;
      cyc(3); chk("rh_v", vld, 2'b01);
      req[0] = 1'b1;
      cyc(3); chk("rh_err", err, {1'b0, ERR});
      rst_n = 1'b0; req = 2'b10;
      cyc(1); chk("rh_rst_v", vld, 2'b00);
      chk("rh_rst_ack", ack, 2'b00);
      chk("rh_rst_err", err, 2'b00);
      chk("rh_rst_data", dout, 32'h0);
      din[31:16] = 16'h5A5A;
      rst_n = 1'b1;
      cyc(2); chk("rh_rel_v_early", vld, 2'b00);
      cyc(1); chk("rh_rel_v", vld, 2'b10);
      chk("rh_rel_data", dout[31:16], 16'h5A5A);
      rdy = 2'b11;
      cyc(1); chk("rh_rel_ack", ack, 2'b10);
      cyc(5); chk("rh_one_capture", vld, 2'b00);
      chk("rh_ack_final", ack, 2'b10);

      // depth sweep: SYNC_STAGES 3 and 4, ready tied high
      din3[15:0] = 16'h0333; din4[15:0] = 16'h0444;
      req3[0] = 1'b1; req4[0] = 1'b1;
      cyc(3); chk("d_v3_e2", vld3[0], 1'b0);
      chk("d_v4_e2", vld4[0], 1'b0);
      cyc(1); chk("d_v3_e3", vld3[0], 1'b1);
      chk("d_d3", dout3[15:0], 16'h0333);
      chk("d_v4_e3", vld4[0], 1'b0);
      cyc(1); chk("d_ack3", ack3[0], 1'b1);
      chk("d_v4_e4", vld4[0], 1'b1);
      chk("d_d4", dout4[15:0], 16'h0444);
      cyc(1); chk("d_ack4", ack4[0], 1'b1);
      chk("d_err34", {err3, err4}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
